// File: rtl/utopia1_cell_receiver.sv
// UTOPIA-1 receive side: pulls one ATM cell at a time from the PHY and presents it to the core
// as a parallel word held until the core acknowledges it by dropping core_ready.
module utopia1_cell_receiver #(
   parameter int CELL_BYTES = 53
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              rx_data,
   input  logic                    rx_soc,
   input  logic                    rx_clav,
   output logic                    rx_en_n,
   input  logic                    core_ready,
   output logic                    cell_valid,
   output logic [8*CELL_BYTES-1:0] cell_data,
   output logic                    sync_err
);

   // state      | meaning
   // S_IDLE     | after reset, waiting for the core to become ready
   // S_WAIT_SOC | reading enabled, hunting for a start-of-cell byte
   // S_RECEIVE  | assembling bytes 1..CELL_BYTES-1
   // S_PRESENT  | full cell on cell_data, waiting for core_ready low
   // S_RELEASE  | acknowledged, waiting for core_ready high again
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_SOC = 3'd1,
      S_RECEIVE  = 3'd2,
      S_PRESENT  = 3'd3,
      S_RELEASE  = 3'd4
   } state_t;

   localparam logic [5:0] LAST_IDX = 6'(CELL_BYTES - 1);

   state_t                    r_state, w_state_nxt;
   logic [5:0]                r_idx, w_idx_nxt;
   logic                      r_rx_en_n, w_rx_en_n_nxt;
   logic                      r_cell_valid, w_cell_valid_nxt;
   logic                      r_sync_err, w_sync_err_nxt;
   logic [8*CELL_BYTES-1:0]   r_cell_data, w_cell_data_nxt;
   logic                      w_capture;
   logic                      w_wr_en;
   logic [5:0]                w_wr_idx;

   // A byte is taken only when our registered enable and the PHY's byte-valid coincide.
   assign w_capture = ~r_rx_en_n & rx_clav;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_idx        <= 6'd0;
         r_rx_en_n    <= 1'b1;
         r_cell_valid <= 1'b0;
         r_sync_err   <= 1'b0;
         r_cell_data  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_rx_en_n    <= w_rx_en_n_nxt;
         r_cell_valid <= w_cell_valid_nxt;
         r_sync_err   <= w_sync_err_nxt;
         r_cell_data  <= w_cell_data_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_idx_nxt        = r_idx;
      w_rx_en_n_nxt    = r_rx_en_n;
      w_cell_valid_nxt = r_cell_valid;
      w_sync_err_nxt   = 1'b0;
      w_wr_en          = 1'b0;
      w_wr_idx         = r_idx;
      case (r_state)
         S_IDLE: begin
            if (core_ready) begin
               w_rx_en_n_nxt = 1'b0;
               w_state_nxt   = S_WAIT_SOC;
            end
         end
         S_WAIT_SOC: begin
            if (w_capture && rx_soc) begin
               w_wr_en     = 1'b1;
               w_wr_idx    = 6'd0;
               w_idx_nxt   = 6'd1;
               w_state_nxt = S_RECEIVE;
            end
         end
         S_RECEIVE: begin
            if (w_capture) begin
               w_wr_en = 1'b1;
               if (rx_soc) begin
                  // PHY lost framing: restart on the new cell rather than deliver a corrupt one.
                  w_wr_idx       = 6'd0;
                  w_idx_nxt      = 6'd1;
                  w_sync_err_nxt = 1'b1;
               end else if (r_idx == LAST_IDX) begin
                  w_idx_nxt        = 6'd0;
                  w_rx_en_n_nxt    = 1'b1;
                  w_cell_valid_nxt = 1'b1;
                  w_state_nxt      = S_PRESENT;
               end else begin
                  w_idx_nxt = r_idx + 6'd1;
               end
            end
         end
         S_PRESENT: begin
            if (!core_ready) begin
               w_cell_valid_nxt = 1'b0;
               w_state_nxt      = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (core_ready) begin
               w_rx_en_n_nxt = 1'b0;
               w_state_nxt   = S_WAIT_SOC;
            end
         end
         default: begin
            w_state_nxt      = S_IDLE;
            w_idx_nxt        = 6'd0;
            w_rx_en_n_nxt    = 1'b1;
            w_cell_valid_nxt = 1'b0;
         end
      endcase
   end

   // Byte 0 lives in the MSBs; only captured bytes ever touch the cell buffer.
   always_comb begin
      w_cell_data_nxt = r_cell_data;
      if (w_wr_en) begin
         w_cell_data_nxt[8*(CELL_BYTES-1-int'(w_wr_idx)) +: 8] = rx_data;
      end
   end

   assign rx_en_n    = r_rx_en_n;
   assign cell_valid = r_cell_valid;
   assign cell_data  = r_cell_data;
   assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_utopia1_cell_receiver.sv
// Bench for utopia1_cell_receiver: queue-based reference of the cell handshake checked every cycle,
// plus directed scenarios with hand-computed timing and byte expectations.
module tb_utopia1_cell_receiver;

   localparam int CB = 53;
   localparam int W  = 8 * CB;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_soc = 1'b0;
   logic          rx_clav = 1'b0;
   logic          core_ready = 1'b0;
   logic          rx_en_n;
   logic          cell_valid;
   logic [W-1:0]  cell_data;
   logic          sync_err;

   int n_cmp = 0;
   int n_bad = 0;

   utopia1_cell_receiver #(.CELL_BYTES(CB)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_soc     (rx_soc),
      .rx_clav    (rx_clav),
      .rx_en_n    (rx_en_n),
      .core_ready (core_ready),
      .cell_valid (cell_valid),
      .cell_data  (cell_data),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] dbyte(input int k);
      return cell_data[8*(CB-1-k) +: 8];
   endfunction

   // Reference: reading is enabled (m_en) only while hunting/assembling; the cell under
   // assembly is a byte queue that is empty until an SOC byte arrives.
   bit           m_started = 1'b0;
   bit           m_en = 1'b0;
   bit           m_valid = 1'b0;
   bit           m_wait_ready = 1'b0;
   bit           m_sync = 1'b0;
   logic [7:0]   m_q[$];
   logic [W-1:0] m_data = '0;

   always begin
      @(posedge clk);
      if (reset) begin
         m_started = 1'b0; m_en = 1'b0; m_valid = 1'b0; m_wait_ready = 1'b0; m_sync = 1'b0;
         m_q.delete();
         m_data = '0;
      end else begin
         automatic bit cap = m_en && rx_clav;
         m_sync = 1'b0;
         if (!m_started) begin
            if (core_ready) begin m_started = 1'b1; m_en = 1'b1; end
         end else if (m_valid) begin
            if (!core_ready) begin m_valid = 1'b0; m_wait_ready = 1'b1; end
         end else if (m_wait_ready) begin
            if (core_ready) begin m_wait_ready = 1'b0; m_en = 1'b1; end
         end else if (cap) begin
            if (rx_soc) begin
               if (m_q.size() > 0) m_sync = 1'b1;
               m_q.delete();
               m_q.push_back(rx_data);
               m_data[8*(CB-1) +: 8] = rx_data;
            end else if (m_q.size() > 0) begin
               m_q.push_back(rx_data);
               m_data[8*(CB-m_q.size()) +: 8] = rx_data;
               if (m_q.size() == CB) begin
                  m_valid = 1'b1; m_en = 1'b0;
                  m_q.delete();
               end
            end
         end
      end
      #1;
      chk("model_rx_en_n", W'(rx_en_n), W'(!m_en));
      chk("model_cell_valid", W'(cell_valid), W'(m_valid));
      chk("model_sync_err", W'(sync_err), W'(m_sync));
      chk("model_cell_data", cell_data, m_data);
   end

   task automatic push_byte(input logic [7:0] d, input logic soc, input logic rdy = 1'b1);
      int n = 0;
      @(negedge clk);
      rx_data = d; rx_soc = soc; rx_clav = 1'b1; core_ready = rdy;
      while (rx_en_n !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_cmp++; n_bad++;
         $display("FAIL push_timeout: rx_en_n=%b after 100 cycles, required 0", rx_en_n);
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_clav = 1'b0; rx_soc = 1'b0;
      end
   endtask

   task automatic push_cell(input logic [7:0] base, input int stall_after, input int stall_n,
                            output time t_first, output time t_last);
      t_first = 0;
      for (int i = 0; i < CB; i++) begin
         push_byte(8'(base + i), i == 0);
         if (i == 0) t_first = $time;
         if (i == stall_after) idle(stall_n);
      end
      t_last = $time;
   endtask

   task automatic ack();
      @(negedge clk); core_ready = 1'b0;
      @(negedge clk); core_ready = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rx_en_n"}, W'(rx_en_n), W'(1));
      chk({tag, "_cell_valid"}, W'(cell_valid), W'(0));
      chk({tag, "_sync_err"}, W'(sync_err), W'(0));
      chk({tag, "_cell_data"}, cell_data, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      time tf, tl;
      repeat (3) @(negedge clk);
      #1 chk_reset_vals("reset");

      // Basic cell, clav held high throughout
      @(negedge clk);
      reset = 1'b0; core_ready = 1'b1; rx_clav = 1'b1; rx_data = 8'h00; rx_soc = 1'b1;
      @(posedge clk); #2;
      chk("en_after_release", W'(rx_en_n), W'(0));
      push_cell(8'h00, -1, 0, tf, tl);
      #2;
      chk("s1_latency", W'(tl - tf), W'(520));
      chk("s1_valid", W'(cell_valid), W'(1));
      chk("s1_byte0", W'(cell_data[W-1 -: 8]), W'(8'h00));
      chk("s1_byte52", W'(cell_data[7:0]), W'(8'h34));
      chk("s1_rx_en_n", W'(rx_en_n), W'(1));

      // Hold ready 5 cycles, drop for 1, raise again
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("s3_valid_hold", W'(cell_valid), W'(1));
      end
      @(negedge clk);
      chk("s3_valid_hold5", W'(cell_valid), W'(1));
      core_ready = 1'b0;
      @(negedge clk);
      chk("s3_valid_clear", W'(cell_valid), W'(0));
      chk("s3_en_still_off", W'(rx_en_n), W'(1));
      core_ready = 1'b1;
      @(posedge clk); #2;
      chk("s3_en_on", W'(rx_en_n), W'(0));

      // Three wait cycles after byte 10
      push_cell(8'h00, 10, 3, tf, tl);
      #2;
      chk("s2_latency", W'(tl - tf), W'(550));
      chk("s2_valid", W'(cell_valid), W'(1));
      chk("s2_byte10", W'(dbyte(10)), W'(8'h0A));
      chk("s2_byte11", W'(dbyte(11)), W'(8'h0B));
      chk("s2_byte12", W'(dbyte(12)), W'(8'h0C));
      ack();

      // Bytes before SOC are discarded
      push_byte(8'hAA, 1'b0);
      push_byte(8'hBB, 1'b0);
      push_cell(8'h10, -1, 0, tf, tl);
      #2;
      chk("s4_byte0", W'(dbyte(0)), W'(8'h10));
      chk("s4_byte1", W'(dbyte(1)), W'(8'h11));
      chk("s4_byte52", W'(dbyte(52)), W'(8'h44));
      ack();

      // SOC re-asserted at index 20
      for (int i = 0; i < 20; i++) push_byte(8'(8'h20 + i), i == 0);
      push_byte(8'h77, 1'b1);
      #2;
      chk("s5_sync_pulse", W'(sync_err), W'(1));
      for (int j = 1; j <= 52; j++) begin
         push_byte(8'(8'h77 + j), 1'b0);
         #2;
         if (j == 1)  chk("s5_sync_cleared", W'(sync_err), W'(0));
         if (j == 51) chk("s5_not_yet_valid", W'(cell_valid), W'(0));
      end
      chk("s5_valid", W'(cell_valid), W'(1));
      chk("s5_byte0", W'(dbyte(0)), W'(8'h77));
      chk("s5_byte52", W'(dbyte(52)), W'(8'hAB));
      ack();

      // Core drops ready in the same cycle as the last byte
      for (int i = 0; i < CB - 1; i++) push_byte(8'(8'h40 + i), i == 0);
      push_byte(8'h74, 1'b0, 1'b0);
      #2;
      chk("s7_valid_rise", W'(cell_valid), W'(1));
      @(posedge clk); #2;
      chk("s7_valid_drop", W'(cell_valid), W'(0));
      @(negedge clk); core_ready = 1'b1;
      @(posedge clk); #2;
      chk("s7_en_on", W'(rx_en_n), W'(0));

      // Reset in the middle of a cell
      for (int i = 0; i < 30; i++) push_byte(8'(8'h90 + i), i == 0);
      @(negedge clk);
      rx_clav = 1'b0; rx_soc = 1'b0; reset = 1'b1;
      #1 chk_reset_vals("s6_midreset");
      @(negedge clk);
      reset = 1'b0;
      push_byte(8'h55, 1'b0);
      push_cell(8'hC0, -1, 0, tf, tl);
      #2;
      chk("s6_valid", W'(cell_valid), W'(1));
      chk("s6_byte0", W'(dbyte(0)), W'(8'hC0));
      chk("s6_byte52", W'(dbyte(52)), W'(8'hF4));
      ack();
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
